// File: rtl/jpc_pc_seq.sv
// jpc_pc_seq: program-counter sequencer with redirect, trap vectoring and return-address stack
module jpc_pc_seq #(
  parameter int ADDR_W = 32,
  parameter int INSN_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 'h100,
  parameter int RAS_DEPTH = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_I,
  input  logic              redirect_I,
  input  logic [ADDR_W-1:0] redirect_pc_I,
  input  logic              call_I,
  input  logic              ret_I,
  input  logic              trap_I,
  output logic [ADDR_W-1:0] pc_O,
  output logic              pc_valid_O,
  output logic              ras_empty_O,
  output logic              ras_full_O,
  output logic              misalign_O,
  output logic              ras_err_O
);
  localparam int NB = ADDR_W / 8;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSN_BYTES);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INSN_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d, rev, tgt_raw, tgt, seq;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, mis_q, mis_d, err_q, err_d, full;

  // Redirect target: optional byte reversal, then forced to instruction alignment
  always_comb begin
    rev = redirect_pc_I;
    for (int i = 0; i < NB; i++) rev[i*8 +: 8] = redirect_pc_I[(NB-1-i)*8 +: 8];
    tgt_raw = BIG_ENDIAN ? rev : redirect_pc_I;
    tgt = tgt_raw & ~MASK;
  end

  // Next-state selection in priority order: trap, redirect(+call), return, advance, hold
  always_comb begin
    seq = pc_q + STEP;
    full = cnt_q == FULL_CNT;
    pc_d = pc_q;
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = err_q;
    mis_d = 1'b0;
    valid_d = 1'b1;
    if (trap_I) begin
      pc_d = TRAP_VEC;
      cnt_d = '0;
    end else if (redirect_I) begin
      pc_d = tgt;
      mis_d = |(tgt_raw & MASK);
      if (call_I) begin
        top_d = top_q + 1'b1;
        ras_d[top_d] = seq;
        cnt_d = full ? cnt_q : cnt_q + 1'b1;
        err_d = err_q | full;
      end
    end else if (ret_I && en_I) begin
      if (cnt_q != '0) begin
        pc_d = ras_q[top_q];
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        pc_d = seq;
        err_d = 1'b1;
      end
    end else if (en_I) begin
      pc_d = seq;
    end
  end

  // State register with asynchronous reset that discards any in-flight stack update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC;
      valid_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      valid_q <= valid_d;
      mis_q <= mis_d;
      err_q <= err_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end

  assign pc_O = pc_q;
  assign pc_valid_O = valid_q;
  assign ras_empty_O = cnt_q == '0;
  assign ras_full_O = cnt_q == FULL_CNT;
  assign misalign_O = mis_q;
  assign ras_err_O = err_q;
endmodule

// File: tb/tb_jpc_pc_seq.sv
// tb_jpc_pc_seq: directed scoreboard bench for jpc_pc_seq
module tb_jpc_pc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, rd = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] pc, pc_be;
  logic valid, empty, full, mis, err;
  logic valid_be, empty_be, full_be, mis_be, err_be;

  typedef struct {
    string name;
    logic [31:0] pc;
    logic [4:0] flags;
    bit chk_be;
    logic [31:0] be_pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  jpc_pc_seq dut (
    .clk(clk), .rst_n(rst_n), .en_I(en), .redirect_I(rd), .redirect_pc_I(rpc),
    .call_I(call), .ret_I(ret), .trap_I(trap), .pc_O(pc), .pc_valid_O(valid),
    .ras_empty_O(empty), .ras_full_O(full), .misalign_O(mis), .ras_err_O(err)
  );

  jpc_pc_seq #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .en_I(en), .redirect_I(rd), .redirect_pc_I(rpc),
    .call_I(call), .ret_I(ret), .trap_I(trap), .pc_O(pc_be), .pc_valid_O(valid_be),
    .ras_empty_O(empty_be), .ras_full_O(full_be), .misalign_O(mis_be), .ras_err_O(err_be)
  );

  always #5 clk = ~clk;

  // Monitor: each falling edge, compare outputs against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if ({pc, valid, empty, full, mis, err} !== {x.pc, x.flags}) begin
        failures++;
        $display("FAIL %s: got pc=%h v/e/f/m/err=%b, want pc=%h v/e/f/m/err=%b",
                 x.name, pc, {valid, empty, full, mis, err}, x.pc, x.flags);
      end
      if (x.chk_be) begin
        checks++;
        if (pc_be !== x.be_pc) begin
          failures++;
          $display("FAIL %s_be: got pc=%h, want pc=%h", x.name, pc_be, x.be_pc);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic r, input logic e, input logic d,
                       input logic [31:0] t, input logic c, input logic rt, input logic tp,
                       input logic [31:0] xpc, input logic [4:0] xf,
                       input bit cb = 1'b0, input logic [31:0] xbe = '0);
    exp_t x;
    @(negedge clk);
    #1;
    rst_n = r; en = e; rd = d; rpc = t; call = c; ret = rt; trap = tp;
    x.name = nm; x.pc = xpc; x.flags = xf; x.chk_be = cb; x.be_pc = xbe;
    sb.push_back(x);
  endtask

  // Flags are {valid, empty, full, misalign, err}
  initial begin
    exp_t x;
    x.name = "reset"; x.pc = 32'h0; x.flags = 5'b01000; x.chk_be = 1'b0; x.be_pc = '0;
    en = 1'b1;
    sb.push_back(x);
    drive("seq4",      1, 1, 0, 0,            0, 0, 0, 32'h4,        5'b11000);
    drive("seq8",      1, 1, 0, 0,            0, 0, 0, 32'h8,        5'b11000);
    drive("seqC",      1, 1, 0, 0,            0, 0, 0, 32'hC,        5'b11000);
    drive("to40",      1, 1, 1, 32'h40,       0, 0, 0, 32'h40,       5'b11000);
    drive("misalign",  1, 0, 1, 32'h1002,     0, 0, 0, 32'h1000,     5'b11010);
    drive("mis_pulse", 1, 0, 0, 0,            0, 0, 0, 32'h1000,     5'b11000);
    drive("big_end",   1, 0, 1, 32'h00100000, 0, 0, 0, 32'h00100000, 5'b11000, 1'b1, 32'h1000);
    drive("to20",      1, 1, 1, 32'h20,       0, 0, 0, 32'h20,       5'b11000);
    drive("call200",   1, 0, 1, 32'h200,      1, 0, 0, 32'h200,      5'b10000);
    drive("seq204",    1, 1, 0, 0,            0, 0, 0, 32'h204,      5'b10000);
    drive("seq208",    1, 1, 0, 0,            0, 0, 0, 32'h208,      5'b10000);
    drive("ret_stall", 1, 0, 0, 0,            0, 1, 0, 32'h208,      5'b10000);
    drive("ret24",     1, 1, 0, 0,            0, 1, 0, 32'h24,       5'b11000);
    drive("call1",     1, 1, 1, 32'h300,      1, 0, 0, 32'h300,      5'b10000);
    drive("call2",     1, 1, 1, 32'h400,      1, 0, 0, 32'h400,      5'b10000);
    drive("call3",     1, 1, 1, 32'h500,      1, 0, 0, 32'h500,      5'b10000);
    drive("call4",     1, 1, 1, 32'h600,      1, 0, 0, 32'h600,      5'b10100);
    drive("call5_ovf", 1, 1, 1, 32'h700,      1, 0, 0, 32'h700,      5'b10101);
    drive("ret1",      1, 1, 0, 0,            0, 1, 0, 32'h604,      5'b10001);
    drive("ret2",      1, 1, 0, 0,            0, 1, 0, 32'h504,      5'b10001);
    drive("ret3",      1, 1, 0, 0,            0, 1, 0, 32'h404,      5'b10001);
    drive("ret4",      1, 1, 0, 0,            0, 1, 0, 32'h304,      5'b11001);
    drive("ret5_unf",  1, 1, 0, 0,            0, 1, 0, 32'h308,      5'b11001);
    drive("call800",   1, 1, 1, 32'h800,      1, 0, 0, 32'h800,      5'b10001);
    drive("trap_all",  1, 1, 1, 32'h900,      0, 1, 1, 32'h100,      5'b11001);
    drive("ret_clr",   1, 1, 0, 0,            0, 1, 0, 32'h104,      5'b11001);
    drive("to_max",    1, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 5'b11001);
    drive("wrap",      1, 1, 0, 0,            0, 0, 0, 32'h0,        5'b11001);
    drive("post_wrap", 1, 1, 0, 0,            0, 0, 0, 32'h4,        5'b11001);
    drive("stall",     1, 0, 0, 0,            0, 0, 0, 32'h4,        5'b11001);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    x.name = "async_rst"; x.pc = 32'h0; x.flags = 5'b01000; x.chk_be = 1'b0; x.be_pc = '0;
    sb.push_back(x);
    drive("rst_rel",   1, 1, 0, 0,            0, 0, 0, 32'h4,        5'b11000);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000, want finish");
    $fatal(1);
  end
endmodule
